divisor_sequencial: RTL

- Sequential restoring divider, the inverse companion of the shift-add multiplier.
- Produces quotient and remainder of WIDTH-bit unsigned operands, one quotient bit per clock.
- Sits beside the multiplier in the MIPS datapath and feeds HI (remainder) and LO (quotient) for DIVU/DIV.
- Start/done handshake matches the multiplier: single St pulse in, Done flag out.

---
 rtl/div_pkg.sv | 22 ++
 rtl/divisor_sequencial_if.sv | 31 +++
 rtl/div_step.sv | 24 ++
 rtl/divisor_sequencial.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// FIX is only reached when the design is built with SIGNED_DIV_EN.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        FIX   = 2'd3
    } div_state_t;

    localparam int DEF_WIDTH = 16;
    localparam int CNT_W     = $clog2(DEF_WIDTH);

    // Wide enough for any supported WIDTH (up to 64); callers slice it.
    localparam logic [63:0] DIVZERO_QUOT = '1;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/divisor_sequencial_if.sv
// Operand/result handshake bundle between the datapath and the divider.
// The Signed input exists only when SIGNED_DIV_EN is defined.
interface divisor_sequencial_if #(parameter int WIDTH = 16);
    logic [WIDTH-1:0] Dividendo;
    logic [WIDTH-1:0] Divisor;
    logic             St;
`ifdef SIGNED_DIV_EN
    logic             Signed;
`endif
    logic [WIDTH-1:0] Quociente;
    logic [WIDTH-1:0] Resto;
    logic             Busy;
    logic             Done;
    logic             DivZero;

    modport master (
`ifdef SIGNED_DIV_EN
        output Signed,
`endif
        output Dividendo, Divisor, St,
        input  Quociente, Resto, Busy, Done, DivZero
    );

    modport slave (
`ifdef SIGNED_DIV_EN
        input  Signed,
`endif
        input  Dividendo, Divisor, St,
        output Quociente, Resto, Busy, Done, DivZero
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract D.
// Purely combinational; the caller owns all registers.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next,
    output logic             ok
);
    logic [WIDTH:0] r_shift;
    logic [WIDTH:0] trial;

    // The stored remainder is always below D, so it fits WIDTH bits; only the
    // shifted value needs the extra bit before the trial subtraction.
    assign r_shift = {r, q[WIDTH-1]};
    assign trial   = r_shift - {1'b0, d};
    assign ok      = ~trial[WIDTH];
    assign r_next  = ok ? trial[WIDTH-1:0] : r_shift[WIDTH-1:0];
    assign q_next  = {q[WIDTH-2:0], ok};

endmodule

// File: rtl/divisor_sequencial.sv
// Sequential restoring divider, one quotient bit per clock, St/Done handshake.
// Define SIGNED_DIV_EN to add the Signed input and the sign-fixup (FIX) state.
module divisor_sequencial
    import div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    divisor_sequencial_if.slave  bus
);
    localparam int CW = cnt_width(WIDTH);

    div_state_t       state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] rem_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             dz_reg;

    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] q_step;
    logic             step_ok;
    logic [WIDTH-1:0] q_shift;
    logic [WIDTH-1:0] dvd_load;
    logic [WIDTH-1:0] dvs_load;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_reg),
        .q      (q_reg),
        .d      (d_reg),
        .r_next (r_step),
        .q_next (q_step),
        .ok     (step_ok)
    );

    assign q_shift = {q_step[WIDTH-1:1], step_ok};

`ifdef SIGNED_DIV_EN
    logic dvd_neg;
    logic dvs_neg;
    logic neg_q_reg;
    logic neg_r_reg;

    // Signed operands are iterated as magnitudes; signs are restored in FIX.
    always_comb begin
        dvd_neg  = bus.Signed & bus.Dividendo[WIDTH-1];
        dvs_neg  = bus.Signed & bus.Divisor[WIDTH-1];
        dvd_load = dvd_neg ? (~bus.Dividendo + WIDTH'(1)) : bus.Dividendo;
        dvs_load = dvs_neg ? (~bus.Divisor + WIDTH'(1)) : bus.Divisor;
    end
`else
    assign dvd_load = bus.Dividendo;
    assign dvs_load = bus.Divisor;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            r_reg     <= '0;
            q_reg     <= '0;
            d_reg     <= '0;
            quo_reg   <= '0;
            rem_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            dz_reg    <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (bus.St) begin
                        d_reg    <= dvs_load;
                        q_reg    <= dvd_load;
                        r_reg    <= '0;
                        done_reg <= 1'b0;
                        dz_reg   <= 1'b0;
`ifdef SIGNED_DIV_EN
                        neg_q_reg <= dvd_neg ^ dvs_neg;
                        neg_r_reg <= dvd_neg;
`endif
                        // Divide-by-zero reports raw bits and finishes on this edge.
                        if (bus.Divisor == '0) begin
                            state_reg <= DONE;
                            quo_reg   <= DIVZERO_QUOT[WIDTH-1:0];
                            rem_reg   <= bus.Dividendo;
                            dz_reg    <= 1'b1;
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                        end else begin
                            state_reg <= SHIFT;
                            cnt_reg   <= CW'(WIDTH - 1);
                            busy_reg  <= 1'b1;
                        end
                    end
                end

                SHIFT: begin
                    r_reg   <= r_step;
                    q_reg   <= q_shift;
                    cnt_reg <= cnt_reg - CW'(1);
                    if (cnt_reg == '0) begin
`ifdef SIGNED_DIV_EN
                        state_reg <= FIX;
`else
                        state_reg <= DONE;
                        quo_reg   <= q_shift;
                        rem_reg   <= r_step;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
`endif
                    end
                end

`ifdef SIGNED_DIV_EN
                FIX: begin
                    state_reg <= DONE;
                    quo_reg   <= neg_q_reg ? (~q_reg + WIDTH'(1)) : q_reg;
                    rem_reg   <= neg_r_reg ? (~r_reg + WIDTH'(1)) : r_reg;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                end
`endif

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.Quociente = quo_reg;
    assign bus.Resto     = rem_reg;
    assign bus.Busy      = busy_reg;
    assign bus.Done      = done_reg;
    assign bus.DivZero   = dz_reg;

endmodule
